adventure_game_inventory: RTL and testbench

//   Parametrised inventory tracker for the adventure game FSM. Generalises the single-sword flag to NUM_ITEMS objects.

---
 rtl/adventure_game_inventory_if.sv | 58 +++++
 rtl/adventure_game_inventory.sv | 144 ++++++++++++++
 tb/tb_adventure_game_inventory.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/adventure_game_inventory_if.sv
// Bundles the inventory tracker's game-side request/status signals.
// Carries no state; latency is set entirely by the attached tracker.
// No backpressure: requests are single-cycle and always answered.
//
// Signals (master = game/room FSM side, slave = inventory tracker):
//   start          game active; low clears the tracker on the next edge
//   room_locate_r  current room code, qualified by room_valid
//   use_req        one-cycle request to use item use_idx
//   use_ack/nack   one-cycle registered answer to use_req
//   held/spent     per-item status vectors
//   held_count     number of items currently held
//   pickup_pulse   per-item one-cycle pickup strobe
interface adventure_game_inventory_if #(
    parameter int ROOM_W    = 3,
    parameter int NUM_ITEMS = 4,
    parameter int IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
    parameter int CNT_W     = $clog2(NUM_ITEMS + 1)
);
    logic                 start;
    logic [ROOM_W-1:0]    room_locate_r;
    logic                 room_valid;
    logic                 use_req;
    logic [IDX_W-1:0]     use_idx;
    logic                 use_ack;
    logic                 use_nack;
    logic [NUM_ITEMS-1:0] held;
    logic [NUM_ITEMS-1:0] spent;
    logic [CNT_W-1:0]     held_count;
    logic [NUM_ITEMS-1:0] pickup_pulse;

    modport master (
        output start,
        output room_locate_r,
        output room_valid,
        output use_req,
        output use_idx,
        input  use_ack,
        input  use_nack,
        input  held,
        input  spent,
        input  held_count,
        input  pickup_pulse
    );

    modport slave (
        input  start,
        input  room_locate_r,
        input  room_valid,
        input  use_req,
        input  use_idx,
        output use_ack,
        output use_nack,
        output held,
        output spent,
        output held_count,
        output pickup_pulse
    );
endinterface

// File: rtl/adventure_game_inventory.sv
// Inventory tracker: NUM_ITEMS objects, each picked up in a fixed room, used USES times, then spent.
// Latency: every output is registered, one cycle after the inputs it reflects.
// No backpressure: each use_req gets exactly one ack or nack pulse the following cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high clear of all state
//   bus    slave side of adventure_game_inventory_if (start, room, use request in;
//          ack/nack, held, spent, held_count, pickup_pulse out)
module adventure_game_inventory #(
    parameter int                          ROOM_W     = 3,
    parameter int                          NUM_ITEMS  = 4,
    parameter logic [NUM_ITEMS*ROOM_W-1:0] ITEM_ROOMS = {3'd6, 3'd5, 3'd4, 3'd3},
    parameter int                          USES       = 1,
    parameter int                          MAX_HELD   = 2,
    parameter int                          IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
    parameter int                          CNT_W      = $clog2(NUM_ITEMS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    adventure_game_inventory_if.slave bus
);

    // Remaining-use counter width; wide enough to hold USES itself.
    localparam int UC_W = $clog2(USES + 1);

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_HELD   = 2'd1,
        ST_SPENT  = 2'd2
    } item_state_t;

    item_state_t          state_q [NUM_ITEMS];
    item_state_t          state_d [NUM_ITEMS];
    logic [UC_W-1:0]      uses_q  [NUM_ITEMS];
    logic [UC_W-1:0]      uses_d  [NUM_ITEMS];

    logic [NUM_ITEMS-1:0] held_q,  held_d;
    logic [NUM_ITEMS-1:0] spent_q, spent_d;
    logic [NUM_ITEMS-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ack_q,   ack_d;
    logic                 nack_q,  nack_d;

    // Pickups granted so far this cycle, scanned in ascending item order.
    int                   granted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                state_q[i] <= ST_ABSENT;
                uses_q[i]  <= UC_W'(USES);
            end
            held_q  <= '0;
            spent_q <= '0;
            pulse_q <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                state_q[i] <= state_d[i];
                uses_q[i]  <= uses_d[i];
            end
            held_q  <= held_d;
            spent_q <= spent_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            state_d[i] = state_q[i];
            uses_d[i]  = uses_q[i];
        end
        pulse_d = '0;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        granted = 0;
        held_d  = '0;
        spent_d = '0;
        count_d = '0;

        if (!bus.start) begin
            // Game idle: return every item to its room with full uses.
            for (int i = 0; i < NUM_ITEMS; i++) begin
                state_d[i] = ST_ABSENT;
                uses_d[i]  = UC_W'(USES);
            end
        end else begin
            // Pickup eligibility and the carry limit look only at pre-edge state,
            // so a slot freed by a use this cycle is not reusable until next cycle.
            if (bus.room_valid) begin
                for (int i = 0; i < NUM_ITEMS; i++) begin
                    if (state_q[i] == ST_ABSENT &&
                        bus.room_locate_r == ITEM_ROOMS[i*ROOM_W +: ROOM_W] &&
                        (int'(count_q) + granted) < MAX_HELD) begin
                        state_d[i] = ST_HELD;
                        pulse_d[i] = 1'b1;
                        granted    = granted + 1;
                    end
                end
            end

            // Only an item already HELD before this edge can be used, so an item
            // being picked up this cycle is refused. An out-of-range index matches
            // no item and falls through to nack.
            if (bus.use_req) begin
                nack_d = 1'b1;
                for (int i = 0; i < NUM_ITEMS; i++) begin
                    if (bus.use_idx == IDX_W'(i) && state_q[i] == ST_HELD) begin
                        ack_d  = 1'b1;
                        nack_d = 1'b0;
                        if (uses_q[i] == UC_W'(1)) begin
                            state_d[i] = ST_SPENT;
                            uses_d[i]  = '0;
                        end else begin
                            uses_d[i] = uses_q[i] - UC_W'(1);
                        end
                    end
                end
            end
        end

        // Status vectors are registered copies of the next state so every
        // output comes straight from a flop.
        for (int i = 0; i < NUM_ITEMS; i++) begin
            held_d[i]  = (state_d[i] == ST_HELD);
            spent_d[i] = (state_d[i] == ST_SPENT);
            count_d    = count_d + CNT_W'(held_d[i]);
        end
    end

    assign bus.use_ack      = ack_q;
    assign bus.use_nack     = nack_q;
    assign bus.held         = held_q;
    assign bus.spent        = spent_q;
    assign bus.held_count   = count_q;
    assign bus.pickup_pulse = pulse_q;

endmodule

// File: tb/tb_adventure_game_inventory.sv
module tb_adventure_game_inventory;

    localparam int ROOM_W    = 3;
    localparam int NUM_ITEMS = 4;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 3;
    localparam int USES      = 1;
    localparam int MAX_HELD  = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    adventure_game_inventory_if #(
        .ROOM_W(ROOM_W), .NUM_ITEMS(NUM_ITEMS), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) bus ();

    adventure_game_inventory #(
        .ROOM_W(ROOM_W), .NUM_ITEMS(NUM_ITEMS),
        .ITEM_ROOMS({3'd6, 3'd5, 3'd4, 3'd3}),
        .USES(USES), .MAX_HELD(MAX_HELD), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model: per-item state 0=absent 1=held 2=spent, plus uses left.
    int   room_of [NUM_ITEMS] = '{3, 4, 5, 6};
    int   st      [NUM_ITEMS];
    int   left    [NUM_ITEMS];
    logic exp_ack, exp_nack;
    logic [NUM_ITEMS-1:0] exp_pp;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_ITEMS; i++) begin
            st[i]   = 0;
            left[i] = USES;
        end
        exp_ack  = 1'b0;
        exp_nack = 1'b0;
        exp_pp   = '0;
    endtask

    task automatic model_step(input bit s, input int room, input bit rv,
                              input bit ureq, input int uidx);
        int pre [NUM_ITEMS];
        int hc;
        int got;
        exp_ack  = 1'b0;
        exp_nack = 1'b0;
        exp_pp   = '0;
        if (!s) begin
            model_clear();
            return;
        end
        hc = 0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            pre[i] = st[i];
            if (st[i] == 1) hc++;
        end
        if (ureq) begin
            if (uidx < NUM_ITEMS && pre[uidx] == 1) begin
                exp_ack = 1'b1;
                left[uidx]--;
                if (left[uidx] == 0) st[uidx] = 2;
            end else begin
                exp_nack = 1'b1;
            end
        end
        if (rv) begin
            got = 0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (pre[i] == 0 && room == room_of[i] && hc + got < MAX_HELD) begin
                    st[i]     = 1;
                    exp_pp[i] = 1'b1;
                    got++;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        logic [NUM_ITEMS-1:0] eh, es;
        int ec;
        ec = 0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            eh[i] = (st[i] == 1);
            es[i] = (st[i] == 2);
            if (st[i] == 1) ec++;
        end
        chk({ph, ".held"},  32'(bus.held),         32'(eh));
        chk({ph, ".spent"}, 32'(bus.spent),        32'(es));
        chk({ph, ".count"}, 32'(bus.held_count),   32'(ec));
        chk({ph, ".pulse"}, 32'(bus.pickup_pulse), 32'(exp_pp));
        chk({ph, ".ack"},   32'(bus.use_ack),      32'(exp_ack));
        chk({ph, ".nack"},  32'(bus.use_nack),     32'(exp_nack));
    endtask

    task automatic step(input bit s, input int room, input bit rv,
                        input bit ureq, input int uidx, input string ph);
        bus.start         = s;
        bus.room_locate_r = ROOM_W'(room);
        bus.room_valid    = rv;
        bus.use_req       = ureq;
        bus.use_idx       = IDX_W'(uidx);
        model_step(s, room, rv, ureq, uidx);
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    // Reset asserted between edges, optionally with a use request in flight.
    task automatic async_reset_mid(input bit with_use, input string ph);
        bus.start      = 1'b1;
        bus.room_valid = 1'b0;
        bus.use_req    = with_use;
        bus.use_idx    = '0;
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_all({ph, ".now"});
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.use_req = 1'b0;
        check_all({ph, ".hold"});
    endtask

    initial begin
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.room_locate_r = '0;
        bus.room_valid    = 1'b0;
        bus.use_req       = 1'b0;
        bus.use_idx       = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");

        // Pickup in room 3 grabs item 0.
        step(1, 3, 1, 0, 0, "pick0");
        // Use it once (USES=1): spent; a second use is refused.
        step(1, 0, 0, 1, 0, "use0");
        step(1, 0, 0, 1, 0, "reuse0");

        // Carry limit: hold items 0 and 1, then room 5 offers item 2.
        step(0, 0, 0, 0, 0, "clr1");
        step(1, 3, 1, 0, 0, "lim.p0");
        step(1, 4, 1, 0, 0, "lim.p1");
        step(1, 5, 1, 0, 0, "lim.full");
        step(1, 0, 0, 1, 0, "lim.use0");
        step(1, 5, 1, 0, 0, "lim.p2");

        // Refusals: absent item, out-of-range index.
        step(0, 0, 0, 0, 0, "clr2");
        step(1, 0, 0, 1, 2, "nack.absent");
        step(1, 0, 0, 1, 5, "nack.range");
        // Use of the item being picked up this same cycle.
        step(1, 3, 1, 1, 0, "nack.same");

        // Same cycle: use held item 0 while picking up item 2.
        step(0, 0, 0, 0, 0, "clr3");
        step(1, 3, 1, 0, 0, "same.p0");
        step(1, 5, 1, 1, 0, "same.both");

        // Async reset while holding, with a use request pending.
        step(1, 4, 1, 0, 0, "arst.p1");
        async_reset_mid(1'b1, "arst");
        step(1, 0, 0, 0, 0, "arst.noack");

        // start low for one cycle mid-game.
        step(1, 3, 1, 0, 0, "sl.p0");
        step(1, 0, 0, 1, 0, "sl.useA");
        step(1, 4, 1, 1, 1, "sl.inflight");
        step(0, 4, 1, 1, 1, "sl.low");

        // Randomised play.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                async_reset_mid($urandom_range(0, 1) == 1, "rnd.arst");
            end else begin
                step($urandom_range(0, 99) < 95,
                     int'($urandom_range(0, 7)),
                     $urandom_range(0, 99) < 70,
                     $urandom_range(0, 99) < 40,
                     int'($urandom_range(0, 7)),
                     "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
